// File: rtl/bcd_cnt_pkg.sv
// bcd_cnt_pkg: shared BCD digit constants and integer-to-BCD conversion
package bcd_cnt_pkg;
  localparam int DIGW = 4;
  localparam logic [DIGW-1:0] BCD_NINE = 4'h9;
  function automatic logic [4*DIGW-1:0] to_bcd(input int v, input int ndig);
    logic [4*DIGW-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      if (i < ndig) r[i*DIGW +: DIGW] = DIGW'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction
endpackage

// File: rtl/bcd_modn_counter_if.sv
// bcd_modn_counter_if: command/status bundle of one BCD modulo-N counter
interface bcd_modn_counter_if #(parameter int NDIG = 2);
  logic ENABLE, UP, CLEAR, LOAD;
  logic [4*NDIG-1:0] DIN, Q;
  logic TC, CO, LOAD_ERR;
  modport master (output ENABLE, UP, CLEAR, LOAD, DIN, input Q, TC, CO, LOAD_ERR);
  modport slave (input ENABLE, UP, CLEAR, LOAD, DIN, output Q, TC, CO, LOAD_ERR);
endinterface

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit step with ripple carry/borrow and forced wrap value
module bcd_digit
  import bcd_cnt_pkg::*;
(
  input  logic [DIGW-1:0] d,
  input  logic [DIGW-1:0] force_val,
  input  logic            step,
  input  logic            up,
  input  logic            wrap,
  output logic [DIGW-1:0] nxt,
  output logic            dig_tc
);
  assign dig_tc = up ? d == BCD_NINE : d == '0;
  assign nxt = wrap ? force_val :
               !step ? d :
               dig_tc ? (up ? '0 : BCD_NINE) :
               up ? d + 1'b1 : d - 1'b1;
endmodule

// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter: NDIG-digit BCD modulo-MODULUS up/down counter with clear, checked load and cascade out
module bcd_modn_counter
  import bcd_cnt_pkg::*;
#(
  parameter int NDIG    = 2,
  parameter int MODULUS = 60
) (
  input logic CLK,
  input logic RESET,
  bcd_modn_counter_if.slave bus
);
  localparam int W = DIGW * NDIG;
  localparam logic [W-1:0] MAXBCD = W'(to_bcd(MODULUS - 1, NDIG));
  logic [W-1:0] q, cnt_nxt, wrap_val;
  logic [NDIG-1:0] dig_ok;
  logic tc, din_ok, load_err;
  assign wrap_val = bus.UP ? '0 : MAXBCD;
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    logic cin, tcd;
    if (i == 0) begin : g_lsd
      assign cin = 1'b1;
    end else begin : g_hi
      assign cin = g_dig[i-1].cin & g_dig[i-1].tcd;
    end
    bcd_digit u_dig (
      .d        (q[i*DIGW +: DIGW]),
      .force_val(wrap_val[i*DIGW +: DIGW]),
      .step     (cin),
      .up       (bus.UP),
      .wrap     (tc),
      .nxt      (cnt_nxt[i*DIGW +: DIGW]),
      .dig_tc   (tcd)
    );
    assign dig_ok[i] = bus.DIN[i*DIGW +: DIGW] <= BCD_NINE;
  end
  // down-terminal is all digits zero, which is exactly the full borrow chain
  assign tc = bus.UP ? q == MAXBCD : g_dig[NDIG-1].cin & g_dig[NDIG-1].tcd;
  assign din_ok = &dig_ok && bus.DIN <= MAXBCD;
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      q <= '0;
      load_err <= 1'b0;
    end else begin
      q <= bus.CLEAR ? '0 : bus.LOAD ? (din_ok ? bus.DIN : q) : bus.ENABLE ? cnt_nxt : q;
      load_err <= !bus.CLEAR && bus.LOAD && !din_ok;
    end
  assign bus.Q = q;
  assign bus.TC = tc;
  assign bus.CO = tc & bus.ENABLE & ~bus.CLEAR & ~bus.LOAD;
  assign bus.LOAD_ERR = load_err;
endmodule

// File: tb/tb_bcd_modn_counter.sv
// tb_bcd_modn_counter: vector table, corner sequences and random model check of bcd_modn_counter
module tb_bcd_modn_counter;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;
  int checks = 0, errors = 0;

  bcd_modn_counter_if #(2) m_if ();
  bcd_modn_counter_if #(2) h_if ();
  bcd_modn_counter_if #(1) d_if ();
  bcd_modn_counter_if #(2) s_if ();
  bcd_modn_counter_if #(2) n_if ();
  bcd_modn_counter_if #(2) r_if ();

  bcd_modn_counter #(.NDIG(2), .MODULUS(60)) u_m (.CLK(CLK), .RESET(RESET), .bus(m_if.slave));
  bcd_modn_counter #(.NDIG(2), .MODULUS(24)) u_h (.CLK(CLK), .RESET(RESET), .bus(h_if.slave));
  bcd_modn_counter #(.NDIG(1), .MODULUS(10)) u_d (.CLK(CLK), .RESET(RESET), .bus(d_if.slave));
  bcd_modn_counter #(.NDIG(2), .MODULUS(60)) u_s (.CLK(CLK), .RESET(RESET), .bus(s_if.slave));
  bcd_modn_counter #(.NDIG(2), .MODULUS(60)) u_n (.CLK(CLK), .RESET(RESET), .bus(n_if.slave));
  bcd_modn_counter #(.NDIG(2), .MODULUS(24)) u_r (.CLK(CLK), .RESET(RESET), .bus(r_if.slave));

  assign n_if.ENABLE = s_if.CO;
  assign r_if.ENABLE = n_if.CO;

  typedef struct packed {
    logic clr, ld, en, up;
    logic [7:0] din, q;
    logic err;
  } vec_t;
  vec_t vecs [16];

  function automatic logic [15:0] tb_bcd(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [7:0] prev;
    logic exp_co;
    int mq;
    {m_if.ENABLE, m_if.UP, m_if.CLEAR, m_if.LOAD, m_if.DIN} = '0;
    {h_if.ENABLE, h_if.UP, h_if.CLEAR, h_if.LOAD, h_if.DIN} = '0;
    {d_if.ENABLE, d_if.UP, d_if.CLEAR, d_if.LOAD, d_if.DIN} = '0;
    {s_if.ENABLE, s_if.UP, s_if.CLEAR, s_if.LOAD, s_if.DIN} = '0;
    {n_if.UP, n_if.CLEAR, n_if.LOAD, n_if.DIN} = '0;
    {r_if.UP, r_if.CLEAR, r_if.LOAD, r_if.DIN} = '0;
    vecs = '{
      '{0, 1, 0, 1, 8'h45, 8'h45, 0}, '{0, 0, 1, 1, 8'h00, 8'h46, 0},
      '{0, 0, 1, 1, 8'h00, 8'h47, 0}, '{0, 0, 1, 1, 8'h00, 8'h48, 0},
      '{0, 1, 1, 1, 8'h60, 8'h48, 1}, '{0, 0, 0, 1, 8'h00, 8'h48, 0},
      '{0, 1, 0, 1, 8'h3A, 8'h48, 1}, '{0, 0, 0, 1, 8'h00, 8'h48, 0},
      '{1, 1, 1, 1, 8'h45, 8'h00, 0}, '{1, 1, 0, 1, 8'h3A, 8'h00, 0},
      '{0, 1, 0, 0, 8'h59, 8'h59, 0}, '{0, 1, 1, 1, 8'h00, 8'h00, 0},
      '{0, 0, 1, 0, 8'h00, 8'h59, 0}, '{0, 0, 1, 1, 8'h00, 8'h00, 0},
      '{0, 1, 0, 1, 8'h99, 8'h00, 1}, '{1, 0, 1, 0, 8'h00, 8'h00, 0}
    };
    #12;
    chk("reset_q", m_if.Q, 8'h00);
    chk("reset_err", m_if.LOAD_ERR, 0);
    chk("reset_tc_down", m_if.TC, 1);
    chk("reset_co", m_if.CO, 0);
    RESET = 1'b1;
    m_if.UP = 1'b1;
    m_if.ENABLE = 1'b1;
    #1 chk("up_tc_at_00", m_if.TC, 0);
    for (int i = 1; i <= 61; i++) begin
      tick;
      chk($sformatf("up_q_%0d", i), m_if.Q, tb_bcd(i % 60));
      chk($sformatf("up_tc_%0d", i), m_if.TC, (i % 60) == 59);
      chk($sformatf("up_co_%0d", i), m_if.CO, (i % 60) == 59);
    end
    m_if.CLEAR = 1'b1;
    tick;
    chk("clear_q", m_if.Q, 8'h00);
    m_if.CLEAR = 1'b0;
    m_if.UP = 1'b0;
    #1 chk("down_tc_00", m_if.TC, 1);
    chk("down_co_00", m_if.CO, 1);
    tick;
    chk("down_wrap", m_if.Q, 8'h59);
    tick;
    chk("down_58", m_if.Q, 8'h58);
    m_if.LOAD = 1'b1;
    m_if.DIN = 8'h10;
    tick;
    chk("load_10", m_if.Q, 8'h10);
    m_if.LOAD = 1'b0;
    tick;
    chk("down_borrow", m_if.Q, 8'h09);
    prev = 8'h09;
    foreach (vecs[k]) begin
      {m_if.CLEAR, m_if.LOAD, m_if.ENABLE, m_if.UP, m_if.DIN} =
        {vecs[k].clr, vecs[k].ld, vecs[k].en, vecs[k].up, vecs[k].din};
      exp_co = (vecs[k].up ? prev == 8'h59 : prev == 8'h00) & vecs[k].en & ~vecs[k].clr & ~vecs[k].ld;
      #1 chk($sformatf("vec%0d_co", k), m_if.CO, exp_co);
      tick;
      chk($sformatf("vec%0d_q", k), m_if.Q, vecs[k].q);
      chk($sformatf("vec%0d_err", k), m_if.LOAD_ERR, vecs[k].err);
      prev = vecs[k].q;
    end
    {m_if.CLEAR, m_if.LOAD, m_if.ENABLE} = '0;
    h_if.LOAD = 1'b1; h_if.DIN = 8'h23; h_if.UP = 1'b1;
    d_if.LOAD = 1'b1; d_if.DIN = 4'h9; d_if.UP = 1'b1;
    tick;
    chk("h_load23", h_if.Q, 8'h23);
    chk("d_load9", d_if.Q, 4'h9);
    h_if.LOAD = 1'b0; h_if.ENABLE = 1'b1;
    d_if.LOAD = 1'b0; d_if.ENABLE = 1'b1;
    #1 chk("h_co23", h_if.CO, 1);
    chk("d_co9", d_if.CO, 1);
    tick;
    chk("h_wrap_up", h_if.Q, 8'h00);
    chk("d_wrap_up", d_if.Q, 4'h0);
    chk("h_co00_up", h_if.CO, 0);
    chk("d_co0_up", d_if.CO, 0);
    h_if.UP = 1'b0; d_if.UP = 1'b0;
    #1 chk("h_tc00_down", h_if.TC, 1);
    chk("h_co00_down", h_if.CO, 1);
    tick;
    chk("h_wrap_down", h_if.Q, 8'h23);
    chk("d_wrap_down", d_if.Q, 4'h9);
    chk("h_co23_down", h_if.CO, 0);
    h_if.LOAD = 1'b1; h_if.DIN = 8'h24;
    d_if.LOAD = 1'b1; d_if.DIN = 4'hA;
    tick;
    chk("h_bad_hold", h_if.Q, 8'h23);
    chk("h_bad_err", h_if.LOAD_ERR, 1);
    chk("d_bad_err", d_if.LOAD_ERR, 1);
    h_if.LOAD = 1'b0; h_if.UP = 1'b1; h_if.DIN = 8'h22;
    d_if.LOAD = 1'b0; d_if.ENABLE = 1'b0;
    tick;
    chk("h_err_clear", h_if.LOAD_ERR, 0);
    chk("d_err_clear", d_if.LOAD_ERR, 0);
    chk("h_up_wrap2", h_if.Q, 8'h00);
    s_if.LOAD = 1'b1; s_if.DIN = 8'h59;
    n_if.LOAD = 1'b1; n_if.DIN = 8'h59;
    r_if.LOAD = 1'b1; r_if.DIN = 8'h23;
    {s_if.UP, n_if.UP, r_if.UP} = 3'b111;
    tick;
    chk("casc_load", {r_if.Q, n_if.Q, s_if.Q}, 24'h235959);
    {s_if.LOAD, n_if.LOAD, r_if.LOAD} = '0;
    s_if.ENABLE = 1'b1;
    #1 chk("casc_co_hr", r_if.CO, 1);
    tick;
    chk("casc_rollover", {r_if.Q, n_if.Q, s_if.Q}, 24'h000000);
    s_if.ENABLE = 1'b0;
    repeat (3) tick;
    chk("casc_freeze", {r_if.Q, n_if.Q, s_if.Q}, 24'h000000);
    {s_if.UP, n_if.UP, r_if.UP} = 3'b000;
    #1 chk("casc_frozen_co", r_if.CO, 0);
    s_if.ENABLE = 1'b1;
    tick;
    chk("casc_down_wrap", {r_if.Q, n_if.Q, s_if.Q}, 24'h235959);
    tick;
    chk("casc_down_next", {r_if.Q, n_if.Q, s_if.Q}, 24'h235958);
    s_if.ENABLE = 1'b0;
    m_if.LOAD = 1'b1; m_if.DIN = 8'h36; m_if.UP = 1'b1;
    tick;
    m_if.LOAD = 1'b0; m_if.ENABLE = 1'b1;
    tick;
    chk("pre_reset_37", m_if.Q, 8'h37);
    m_if.LOAD = 1'b1; m_if.DIN = 8'h77;
    tick;
    chk("pre_reset_err", m_if.LOAD_ERR, 1);
    m_if.LOAD = 1'b0;
    #2 RESET = 1'b0;
    #1 chk("async_reset_q", m_if.Q, 8'h00);
    chk("async_reset_err", m_if.LOAD_ERR, 0);
    tick;
    chk("reset_held_q", m_if.Q, 8'h00);
    #2 RESET = 1'b1;
    tick;
    chk("resume_01", m_if.Q, 8'h01);
    tick;
    chk("resume_02", m_if.Q, 8'h02);
    mq = 2;
    for (int it = 0; it < 400; it++) begin
      int hi, lo, val;
      logic ok;
      m_if.CLEAR = $urandom_range(0, 7) == 0;
      m_if.LOAD = $urandom_range(0, 3) == 0;
      m_if.ENABLE = $urandom_range(0, 1) == 1;
      m_if.UP = $urandom_range(0, 1) == 1;
      m_if.DIN = $urandom_range(0, 1) == 1 ? 8'(tb_bcd($urandom_range(0, 59))) : 8'($urandom);
      hi = int'(m_if.DIN[7:4]);
      lo = int'(m_if.DIN[3:0]);
      val = hi * 10 + lo;
      ok = hi <= 9 && lo <= 9 && val < 60;
      exp_co = (m_if.UP ? mq == 59 : mq == 0) && m_if.ENABLE && !m_if.CLEAR && !m_if.LOAD;
      #1 chk("rnd_co", m_if.CO, exp_co);
      if (m_if.CLEAR) mq = 0;
      else if (m_if.LOAD) mq = ok ? val : mq;
      else if (m_if.ENABLE) mq = m_if.UP ? (mq + 1) % 60 : (mq + 59) % 60;
      tick;
      chk("rnd_q", m_if.Q, tb_bcd(mq));
      chk("rnd_err", m_if.LOAD_ERR, !m_if.CLEAR && m_if.LOAD && !ok);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
